// File: rtl/complex_accumulator_pkg.sv
// Shared state encoding and default widths for the complex accumulator.
package complex_acc_pkg;

   localparam int DEF_IN_W  = 17;
   localparam int DEF_LEN_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      HOLD  = 2'b10
   } state_t;

endpackage

// File: rtl/complex_accumulator_if.sv
// Product-in / sum-out handshake bundle of the complex accumulator.
interface complex_accumulator_if
   import complex_acc_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int LEN_W = DEF_LEN_W
);
   localparam int ACC_W = IN_W + LEN_W;

   logic                    in_val;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_re;
   logic signed [IN_W-1:0]  in_im;
   logic [LEN_W-1:0]        acc_len;
   logic                    out_val;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_re;
   logic signed [ACC_W-1:0] out_im;

   // the accumulator side
   modport slave (
      input  in_val, in_re, in_im, acc_len, out_ready,
      output in_ready, out_val, out_re, out_im
   );

   // producer/consumer side
   modport master (
      output in_val, in_re, in_im, acc_len, out_ready,
      input  in_ready, out_val, out_re, out_im
   );
endinterface

// File: rtl/complex_accumulator_lane.sv
// One signed accumulator register: clear, load (sign-extended) or add.
module complex_acc_lane #(
   parameter int IN_W  = 17,
   parameter int ACC_W = 25
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic             add,
   input  logic [IN_W-1:0]  din,
   output logic [ACC_W-1:0] q
);
   logic [ACC_W-1:0] din_ext;

   assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

   // clear wins over load, load over add; otherwise hold
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)     q <= '0;
      else if (clr)  q <= '0;
      else if (load) q <= din_ext;
      else if (add)  q <= q + din_ext;
   end
endmodule

// File: rtl/complex_accumulator.sv
// Sums bursts of acc_len complex products into one registered complex result.
module complex_accumulator
   import complex_acc_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   sw_rst,
   complex_accumulator_if.slave   bus
);
   localparam int ACC_W = IN_W + LEN_W;
   localparam int LANES = 2;  // 0 = real, 1 = imaginary

   state_t                        state_q, state_d;
   logic [LEN_W-1:0]              cnt_q, len_q, eff_len;
   logic                          beat, last, clr, load, add;
   logic [LANES-1:0][IN_W-1:0]    din;
   logic [LANES-1:0][ACC_W-1:0]   acc;

   // handshake outputs decode the state register only
   assign bus.in_ready = (state_q != HOLD);
   assign bus.out_val  = (state_q == HOLD);

   assign beat    = bus.in_val && bus.in_ready;
   assign eff_len = (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;
   assign last    = ((cnt_q + 1'b1) == len_q);

   // next state and lane controls
   always_comb begin
      state_d = state_q;
      clr     = sw_rst;
      load    = 1'b0;
      add     = 1'b0;
      case (state_q)
         IDLE: if (beat) begin
            load    = 1'b1;
            state_d = (eff_len == LEN_W'(1)) ? HOLD : ACCUM;
         end
         ACCUM: if (beat) begin
            add = 1'b1;
            if (last) state_d = HOLD;
         end
         HOLD: if (bus.out_ready) begin
            clr     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (sw_rst) state_d = IDLE;
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // beat counter and burst length captured on the first beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (sw_rst) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (state_q == IDLE && beat) begin
         cnt_q <= LEN_W'(1);
         len_q <= eff_len;
      end else if (state_q == ACCUM && beat) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (state_q == HOLD && bus.out_ready) begin
         cnt_q <= '0;
      end
   end

   assign din[0] = bus.in_re;
   assign din[1] = bus.in_im;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      complex_acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
         .clk  (clk),
         .rstn (rstn),
         .clr  (clr),
         .load (load),
         .add  (add),
         .din  (din[l]),
         .q    (acc[l])
      );
   end

   assign bus.out_re = acc[0];
   assign bus.out_im = acc[1];
endmodule
